// File: rtl/fp_pkg.sv
// Shared binary32 constants and the float_to_int FSM state encoding.
package fp_pkg;

  localparam int          FP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;

  localparam logic [31:0] INT32_MAX  = 32'h7FFFFFFF;
  localparam logic [31:0] INT32_MIN  = 32'h80000000;

  localparam logic [2:0]  ST_IDLE    = 3'd0;
  localparam logic [2:0]  ST_SHIFT   = 3'd1;
  localparam logic [2:0]  ST_ROUND   = 3'd2;
  localparam logic [2:0]  ST_PACK    = 3'd3;
  localparam logic [2:0]  ST_OUTPUT  = 3'd4;

endpackage

// File: rtl/fp_unpack.sv
// Combinational binary32 field split and classification, shared with the adder.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0] op,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [22:0] mant,
  output logic        is_nan,
  output logic        is_inf,
  output logic        is_zero,
  output logic        is_denorm
);

  assign sign      = op[31];
  assign exp       = op[30:23];
  assign mant      = op[22:0];
  assign is_nan    = (exp == FP_EXP_MAX) && (mant != 23'd0);
  assign is_inf    = (exp == FP_EXP_MAX) && (mant == 23'd0);
  assign is_zero   = (exp == 8'd0) && (mant == 23'd0);
  assign is_denorm = (exp == 8'd0) && (mant != 23'd0);

endmodule

// File: rtl/float_to_int.sv
// Multi-cycle binary32 -> int32 converter (fcvt.w.s), one significand shift per cycle.
// Build option: define FCVT_RNE_EN for round-to-nearest-even, otherwise round toward zero.
module float_to_int
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  output logic [31:0] c,
  output logic        invalid,
  output logic        done,
  output logic [2:0]  state
);

  logic        u_sign;
  logic [7:0]  u_exp;
  logic [22:0] u_mant;
  logic        u_nan, u_inf, u_zero, u_denorm;

  fp_unpack u_unpack (
    .op        (a),
    .sign      (u_sign),
    .exp       (u_exp),
    .mant      (u_mant),
    .is_nan    (u_nan),
    .is_inf    (u_inf),
    .is_zero   (u_zero),
    .is_denorm (u_denorm)
  );

  logic signed [9:0] exp_unb;
  assign exp_unb = $signed({2'b00, u_exp}) - 10'(FP_BIAS);

  // Classification of the operand at the accepting edge.
  logic        special;
  logic [31:0] spec_c;
  logic        spec_inv;
  logic [4:0]  k_init;
  logic        left_init;

  always_comb begin
    special  = 1'b1;
    spec_c   = 32'd0;
    spec_inv = 1'b0;
    if (u_nan) begin
      spec_c   = INT32_MAX;
      spec_inv = 1'b1;
    end else if (u_inf || exp_unb > 10'sd31) begin
      spec_c   = u_sign ? INT32_MIN : INT32_MAX;
      spec_inv = 1'b1;
    end else if (exp_unb == 10'sd31) begin
      spec_c   = u_sign ? INT32_MIN : INT32_MAX;
      spec_inv = !u_sign || (u_mant != 23'd0);
    end else if (u_zero || u_denorm) begin
      spec_c   = 32'd0;
    end else begin
      special  = 1'b0;
    end
  end

  // Right shifts past 25 cannot change the rounded result, so they are capped.
  always_comb begin
    left_init = 1'b0;
    if (exp_unb >= 10'sd23) begin
      left_init = 1'b1;
      k_init    = 5'(exp_unb - 10'sd23);
    end else if (exp_unb < -10'sd2) begin
      k_init    = 5'd25;
    end else begin
      k_init    = 5'(10'sd23 - exp_unb);
    end
  end

  logic [2:0]  state_reg, state_next;
  logic        sign_reg;
  logic        left_reg;
  logic [4:0]  k_reg;
  logic [33:0] mag_reg;   // {int[31:0], G, S}

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = special ? ST_OUTPUT : ST_SHIFT;
      ST_SHIFT:  if (k_reg == 5'd0) state_next = ST_ROUND;
      ST_ROUND:  state_next = ST_PACK;
      ST_PACK:   state_next = ST_OUTPUT;
      ST_OUTPUT: if (!start) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    done  = (state_reg == ST_OUTPUT);
    state = state_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_reg <= 1'b0;
      left_reg <= 1'b0;
      k_reg    <= 5'd0;
      mag_reg  <= 34'd0;
      c        <= 32'd0;
      invalid  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            sign_reg <= u_sign;
            if (special) begin
              c       <= spec_c;
              invalid <= spec_inv;
            end else begin
              mag_reg  <= {8'd0, 1'b1, u_mant, 2'b00};
              k_reg    <= k_init;
              left_reg <= left_init;
            end
          end
        end
        ST_SHIFT: begin
          if (k_reg != 5'd0) begin
            k_reg <= k_reg - 5'd1;
            if (left_reg) mag_reg <= {mag_reg[32:0], 1'b0};
            else          mag_reg <= {1'b0, mag_reg[33:3], mag_reg[2], mag_reg[1] | mag_reg[0]};
          end
        end
        ST_ROUND: begin
`ifdef FCVT_RNE_EN
          if (mag_reg[1] && (mag_reg[0] || mag_reg[2]))
            mag_reg[33:2] <= mag_reg[33:2] + 32'd1;
`endif
        end
        ST_PACK: begin
          c       <= sign_reg ? (32'd0 - mag_reg[33:2]) : mag_reg[33:2];
          invalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Directed-vector bench for float_to_int; expectations depend on FCVT_RNE_EN.
module tb_float_to_int;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] c;
  logic        invalid;
  logic        done;
  logic [2:0]  state;

  int n_assert;
  int n_fail;

  float_to_int dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .c       (c),
    .invalid (invalid),
    .done    (done),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one start pulse and counts edges until done; lat=-1 on timeout.
  task automatic do_convert(input logic [31:0] val, output logic [31:0] oc,
                            output logic oinv, output int lat);
    @(negedge clk);
    a     = val;
    start = 1'b1;
    lat   = -1;
    oc    = 32'hDEADBEEF;
    oinv  = 1'bx;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat  = i;
        oc   = c;
        oinv = invalid;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    #12;
    n_assert++;
    if (state !== 3'd0 || c !== 32'd0 || invalid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: state=%0d c=%h inv=%b done=%b, want 0/0/0/0", state, c, invalid, done);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_vectors();
    logic [31:0] va [15];
    logic [31:0] vc [15];
    logic        vi [15];
    int          vl [15];
    logic [31:0] oc;
    logic        oinv;
    int          lat;
    va[0]  = 32'h3F800000; vc[0]  = 32'd1;          vi[0]  = 0; vl[0]  = 27;
    va[1]  = 32'h47F12000; vc[1]  = 32'h0001E240;   vi[1]  = 0; vl[1]  = 11;
`ifdef FCVT_RNE_EN
    va[2]  = 32'h40600000; vc[2]  = 32'd4;          vi[2]  = 0; vl[2]  = 26;
    va[9]  = 32'h3F400000; vc[9]  = 32'd1;          vi[9]  = 0; vl[9]  = 28;
    va[12] = 32'hBFC00000; vc[12] = 32'hFFFFFFFE;   vi[12] = 0; vl[12] = 27;
`else
    va[2]  = 32'h40600000; vc[2]  = 32'd3;          vi[2]  = 0; vl[2]  = 26;
    va[9]  = 32'h3F400000; vc[9]  = 32'd0;          vi[9]  = 0; vl[9]  = 28;
    va[12] = 32'hBFC00000; vc[12] = 32'hFFFFFFFF;   vi[12] = 0; vl[12] = 27;
`endif
    va[3]  = 32'hC0200000; vc[3]  = 32'hFFFFFFFE;   vi[3]  = 0; vl[3]  = 26;
    va[4]  = 32'h4F000000; vc[4]  = 32'h7FFFFFFF;   vi[4]  = 1; vl[4]  = 1;
    va[5]  = 32'hCF000000; vc[5]  = 32'h80000000;   vi[5]  = 0; vl[5]  = 1;
    va[6]  = 32'h7FC00000; vc[6]  = 32'h7FFFFFFF;   vi[6]  = 1; vl[6]  = 1;
    va[7]  = 32'h3F000000; vc[7]  = 32'd0;          vi[7]  = 0; vl[7]  = 28;
    va[8]  = 32'h00000001; vc[8]  = 32'd0;          vi[8]  = 0; vl[8]  = 1;
    va[10] = 32'hFF800000; vc[10] = 32'h80000000;   vi[10] = 1; vl[10] = 1;
    va[11] = 32'h4EFFFFFF; vc[11] = 32'h7FFFFF80;   vi[11] = 0; vl[11] = 11;
    va[13] = 32'h3E800000; vc[13] = 32'd0;          vi[13] = 0; vl[13] = 29;
    va[14] = 32'hCF000001; vc[14] = 32'h80000000;   vi[14] = 1; vl[14] = 1;
    for (int i = 0; i < 15; i++) begin
      do_convert(va[i], oc, oinv, lat);
      n_assert++;
      if (oc !== vc[i] || oinv !== vi[i] || lat !== vl[i]) begin
        n_fail++;
        $display("FAIL vec a=%h: c=%h inv=%b lat=%0d, want c=%h inv=%b lat=%0d",
                 va[i], oc, oinv, lat, vc[i], vi[i], vl[i]);
      end else begin
        $display("vec a=%h c=%h inv=%b lat=%0d ok", va[i], oc, oinv, lat);
      end
    end
  endtask

  task automatic test_hold_start();
    @(negedge clk);
    a     = 32'h4F000000;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_assert++;
      if (done !== 1'b1 || state !== 3'd4 || c !== 32'h7FFFFFFF) begin
        n_fail++;
        $display("FAIL hold cyc%0d: done=%b state=%0d c=%h, want 1/4/7fffffff", i, done, state, c);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    n_assert++;
    if (state !== 3'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: state=%0d done=%b, want 0/0", state, done);
    end
    $display("hold start through OUTPUT checked");
  endtask

  task automatic test_ignore_busy();
    logic [31:0] oc;
    int          lat;
    @(negedge clk);
    a     = 32'h47F12000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    a     = 32'h3F800000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    oc    = 32'hDEADBEEF;
    for (int i = 3; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        oc  = c;
        break;
      end
    end
    n_assert++;
    if (oc !== 32'h0001E240 || lat !== 11) begin
      n_fail++;
      $display("FAIL ignore_busy: c=%h lat=%0d, want 0001e240 lat=11", oc, lat);
    end else begin
      $display("busy start ignored c=%h lat=%0d", oc, lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    a     = 32'h3F800000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_assert++;
    if (state !== 3'd1 || c !== 32'h0001E240) begin
      n_fail++;
      $display("FAIL mid_state: state=%0d c=%h, want 1/0001e240", state, c);
    end
    #2;
    rst = 1'b0;
    #1;
    n_assert++;
    if (state !== 3'd0 || c !== 32'd0 || done !== 1'b0 || invalid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: state=%0d c=%h done=%b inv=%b, want 0/0/0/0", state, c, done, invalid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_assert++;
    if (state !== 3'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: state=%0d, want 0", state);
    end
    $display("async reset mid-SHIFT checked");
  endtask

  task automatic test_back_to_back();
    logic [31:0] oc;
    logic        oinv;
    int          lat;
    do_convert(32'hC0200000, oc, oinv, lat);
    n_assert++;
    if (oc !== 32'hFFFFFFFE || oinv !== 1'b0 || lat !== 26) begin
      n_fail++;
      $display("FAIL b2b_first: c=%h inv=%b lat=%0d, want fffffffe 0 26", oc, oinv, lat);
    end
    do_convert(32'h7FC00000, oc, oinv, lat);
    n_assert++;
    if (oc !== 32'h7FFFFFFF || oinv !== 1'b1 || lat !== 1) begin
      n_fail++;
      $display("FAIL b2b_second: c=%h inv=%b lat=%0d, want 7fffffff 1 1", oc, oinv, lat);
    end
    do_convert(32'h3F800000, oc, oinv, lat);
    n_assert++;
    if (oc !== 32'd1 || oinv !== 1'b0 || lat !== 27) begin
      n_fail++;
      $display("FAIL b2b_third: c=%h inv=%b lat=%0d, want 1 0 27", oc, oinv, lat);
    end
    $display("back-to-back conversions checked");
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_vectors();
    test_hold_start();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
